// File: rtl/wash_cycle_ctrl.sv
// wash_cycle_ctrl: coin-operated washer controller with self-timed soak/wash/rinse/spin phases
// Ports:
//   clk, reset (async, active-high), tick (phase time base enable)
//   botao_50cent / botao_1real: coin pulses (+1 / +2 credit units), cancelar: refund in ESPERA
//   lid_r: lid open, n_rodadas: requested wash/rinse rounds (latched at start)
//   molho/lavar/enxague/centrifugar/pausar/parada: one-hot phase decode of the state
//   credito: current credit, troco/troco_valid: change pulse, fim: cycle-complete pulse
module wash_cycle_ctrl #(
  parameter int PRICE       = 4,
  parameter int CREDIT_W    = 4,
  parameter int T_MOLHO     = 8,
  parameter int T_LAVAR     = 12,
  parameter int T_ENXAGUE   = 6,
  parameter int T_CENTRIF   = 10,
  parameter int TMR_W       = 8,
  parameter int MAX_RODADAS = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic                botao_50cent,
  input  logic                botao_1real,
  input  logic                cancelar,
  input  logic                lid_r,
  input  logic [1:0]          n_rodadas,
  output logic                molho,
  output logic                lavar,
  output logic                enxague,
  output logic                centrifugar,
  output logic                pausar,
  output logic                parada,
  output logic [CREDIT_W-1:0] credito,
  output logic [CREDIT_W-1:0] troco,
  output logic                troco_valid,
  output logic                fim
);
  localparam int RW = $clog2(MAX_RODADAS + 1);
  typedef enum logic [2:0] {S_ESPERA, S_MOLHO, S_LAVAR, S_ENXAGUE, S_CENTRIF, S_PAUSAR} state_t;
  state_t              r_state;
  logic [TMR_W-1:0]    r_timer;
  logic [RW-1:0]       r_rod;
  logic [CREDIT_W-1:0] r_credito;
  logic [CREDIT_W-1:0] r_troco;
  logic                r_tv;
  logic                r_fim;
  logic [CREDIT_W:0]   w_sum;
  logic                w_start;
  logic                w_last;
  logic [RW-1:0]       w_rod;
  assign w_sum   = {1'b0, r_credito} + {{(CREDIT_W-1){1'b0}}, botao_1real, botao_50cent};
  assign w_start = r_credito >= CREDIT_W'(PRICE) && !lid_r;
  // final tick of the current phase: exit on this edge instead of decrementing
  assign w_last  = tick && r_timer == TMR_W'(1);
  assign w_rod   = RW'(n_rodadas == 2'd0 ? 1 :
                       (int'(n_rodadas) > MAX_RODADAS ? MAX_RODADAS : int'(n_rodadas)));
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_ESPERA;
      r_timer   <= '0;
      r_rod     <= '0;
      r_credito <= '0;
      r_troco   <= '0;
      r_tv      <= 1'b0;
      r_fim     <= 1'b0;
    end else begin
      r_tv  <= 1'b0;
      r_fim <= 1'b0;
      case (r_state)
        S_ESPERA:
          if (w_start) begin
            r_state   <= S_MOLHO;
            r_timer   <= TMR_W'(T_MOLHO);
            r_rod     <= w_rod;
            r_troco   <= r_credito - CREDIT_W'(PRICE);
            r_tv      <= 1'b1;
            r_credito <= '0;
          end else if (cancelar && r_credito != '0) begin
            r_troco   <= r_credito;
            r_tv      <= 1'b1;
            r_credito <= '0;
          end else begin
            // at most +3 per cycle, so a single carry bit flags saturation
            r_credito <= w_sum[CREDIT_W] ? '1 : w_sum[CREDIT_W-1:0];
          end
        S_MOLHO:
          if (w_last) begin
            r_state <= S_LAVAR;
            r_timer <= TMR_W'(T_LAVAR);
          end else if (tick) r_timer <= r_timer - TMR_W'(1);
        S_LAVAR:
          if (w_last) begin
            r_state <= S_ENXAGUE;
            r_timer <= TMR_W'(T_ENXAGUE);
          end else if (tick) r_timer <= r_timer - TMR_W'(1);
        S_ENXAGUE:
          if (w_last) begin
            r_rod   <= r_rod - RW'(1);
            r_state <= r_rod <= RW'(1) ? S_CENTRIF : S_LAVAR;
            r_timer <= r_rod <= RW'(1) ? TMR_W'(T_CENTRIF) : TMR_W'(T_LAVAR);
          end else if (tick) r_timer <= r_timer - TMR_W'(1);
        S_CENTRIF:
          // lid-open wins over expiry and leaves the remaining time untouched
          if (lid_r) r_state <= S_PAUSAR;
          else if (w_last) begin
            r_state <= S_ESPERA;
            r_timer <= '0;
            r_fim   <= 1'b1;
          end else if (tick) r_timer <= r_timer - TMR_W'(1);
        S_PAUSAR:
          if (!lid_r) r_state <= S_CENTRIF;
        default: r_state <= S_ESPERA;
      endcase
    end
  end
  assign parada      = r_state == S_ESPERA;
  assign molho       = r_state == S_MOLHO;
  assign lavar       = r_state == S_LAVAR;
  assign enxague     = r_state == S_ENXAGUE;
  assign centrifugar = r_state == S_CENTRIF;
  assign pausar      = r_state == S_PAUSAR;
  assign credito     = r_credito;
  assign troco       = r_troco;
  assign troco_valid = r_tv;
  assign fim         = r_fim;
endmodule

// File: tb/tb_wash_cycle_ctrl.sv
// tb_wash_cycle_ctrl: self-checking bench for wash_cycle_ctrl (vector table + phase timing sequences)
module tb_wash_cycle_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b1;
  logic       botao_50cent = 1'b0;
  logic       botao_1real = 1'b0;
  logic       cancelar = 1'b0;
  logic       lid_r = 1'b0;
  logic [1:0] n_rodadas = 2'd1;
  logic       molho, lavar, enxague, centrifugar, pausar, parada;
  logic [3:0] credito, troco;
  logic       troco_valid, fim;
  int total = 0;
  int bad = 0;
  localparam logic [5:0] MOL = 6'b100000;
  localparam logic [5:0] LAV = 6'b010000;
  localparam logic [5:0] ENX = 6'b001000;
  localparam logic [5:0] CEN = 6'b000100;
  localparam logic [5:0] PAU = 6'b000010;
  localparam logic [5:0] PAR = 6'b000001;
  wash_cycle_ctrl dut (
    .clk(clk), .reset(reset), .tick(tick),
    .botao_50cent(botao_50cent), .botao_1real(botao_1real),
    .cancelar(cancelar), .lid_r(lid_r), .n_rodadas(n_rodadas),
    .molho(molho), .lavar(lavar), .enxague(enxague),
    .centrifugar(centrifugar), .pausar(pausar), .parada(parada),
    .credito(credito), .troco(troco), .troco_valid(troco_valid), .fim(fim)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic       rs, c50, c1, canc, lid;
    logic [3:0] cred;
    logic       tv;
    logic [3:0] tr;
    logic [5:0] p;
  } vec_t;
  vec_t tbl[$];
  vec_t exp_q[$];
  function automatic vec_t mk(logic rs, logic c50, logic c1, logic canc, logic lid,
                              logic [3:0] cred, logic tv, logic [3:0] tr, logic [5:0] p);
    vec_t v;
    v.rs = rs; v.c50 = c50; v.c1 = c1; v.canc = canc; v.lid = lid;
    v.cred = cred; v.tv = tv; v.tr = tr; v.p = p;
    return v;
  endfunction
  function automatic logic [5:0] ph();
    return {molho, lavar, enxague, centrifugar, pausar, parada};
  endfunction
  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask
  task automatic tk();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic measure(input logic [5:0] p, input int d, input string nm);
    int n = 0;
    bit oh = 1'b1;
    while (ph() == p && n < 200) begin
      oh &= $onehot(ph());
      n++;
      tk();
    end
    chk(nm, n, d);
    chk({nm, "_onehot"}, int'(oh), 1);
  endtask
  task automatic pay_start(input logic [1:0] nr);
    n_rodadas = nr;
    botao_1real = 1'b1;
    tk();
    tk();
    botao_1real = 1'b0;
    tk();
    n_rodadas = 2'd0;
    chk("start_molho", int'(ph()), int'(MOL));
  endtask
  task automatic run(input logic [1:0] nr, input int rounds, input string nm);
    pay_start(nr);
    measure(MOL, 8, {nm, "_molho"});
    for (int r = 0; r < rounds; r++) begin
      measure(LAV, 12, {nm, "_lavar"});
      measure(ENX, 6, {nm, "_enxague"});
    end
    measure(CEN, 10, {nm, "_centrif"});
    chk({nm, "_end_parada"}, int'(ph()), int'(PAR));
    chk({nm, "_fim"}, int'(fim), 1);
    tk();
    chk({nm, "_fim_drop"}, int'(fim), 0);
  endtask
  initial begin
    vec_t v, e;
    tbl.push_back(mk(1,0,0,0,0, 0,0,0,PAR));
    tbl.push_back(mk(0,1,0,0,0, 1,0,0,PAR));
    tbl.push_back(mk(0,0,1,0,0, 3,0,0,PAR));
    tbl.push_back(mk(0,1,0,0,0, 4,0,0,PAR));
    tbl.push_back(mk(0,0,0,0,0, 0,1,0,MOL));
    tbl.push_back(mk(0,0,0,1,0, 0,0,0,MOL));
    tbl.push_back(mk(0,0,1,0,0, 0,0,0,MOL));
    tbl.push_back(mk(1,0,0,0,0, 0,0,0,PAR));
    tbl.push_back(mk(0,0,0,1,0, 0,0,0,PAR));
    tbl.push_back(mk(0,1,1,0,0, 3,0,0,PAR));
    tbl.push_back(mk(0,0,0,1,0, 0,1,3,PAR));
    tbl.push_back(mk(0,0,1,0,0, 2,0,0,PAR));
    tbl.push_back(mk(0,0,1,0,1, 4,0,0,PAR));
    tbl.push_back(mk(0,0,0,0,1, 4,0,0,PAR));
    tbl.push_back(mk(0,0,1,0,1, 6,0,0,PAR));
    tbl.push_back(mk(0,1,0,1,0, 0,1,2,MOL));
    tbl.push_back(mk(1,0,0,0,0, 0,0,0,PAR));
    for (int i = 1; i <= 8; i++)
      tbl.push_back(mk(0,0,1,0,1, (i == 8) ? 4'd15 : 4'(2 * i),0,0,PAR));
    tbl.push_back(mk(0,1,0,0,1, 15,0,0,PAR));
    tbl.push_back(mk(0,0,0,0,0, 0,1,11,MOL));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,MOL));
    tbl.push_back(mk(1,0,0,0,0, 0,0,0,PAR));
    @(negedge clk);
    foreach (tbl[i]) begin
      v = tbl[i];
      reset = v.rs;
      botao_50cent = v.c50;
      botao_1real = v.c1;
      cancelar = v.canc;
      lid_r = v.lid;
      exp_q.push_back(v);
      tk();
      e = exp_q.pop_front();
      chk($sformatf("row%0d_credito", i), int'(credito), int'(e.cred));
      chk($sformatf("row%0d_troco_valid", i), int'(troco_valid), int'(e.tv));
      chk($sformatf("row%0d_phase", i), int'(ph()), int'(e.p));
      if (e.tv || e.rs) chk($sformatf("row%0d_troco", i), int'(troco), int'(e.tr));
    end
    reset = 1'b0;
    botao_50cent = 1'b0;
    botao_1real = 1'b0;
    cancelar = 1'b0;
    lid_r = 1'b0;
    tk();
    run(2'd2, 2, "run2");
    run(2'd0, 1, "run0");
    run(2'd3, 3, "run3");
    pay_start(2'd1);
    measure(MOL, 8, "lid_molho");
    measure(LAV, 12, "lid_lavar");
    measure(ENX, 6, "lid_enxague");
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("lid_spin_pre%0d", i), int'(ph()), int'(CEN));
      if (i == 4) lid_r = 1'b1;
      tk();
    end
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("lid_pause%0d", i), int'(ph()), int'(PAU));
      if (i == 4) lid_r = 1'b0;
      tk();
    end
    measure(CEN, 6, "lid_spin_post");
    chk("lid_fim", int'(fim), 1);
    tk();
    pay_start(2'd1);
    tick = 1'b0;
    repeat (5) tk();
    tick = 1'b1;
    measure(MOL, 8, "stretch_molho");
    botao_1real = 1'b1;
    tk();
    botao_1real = 1'b0;
    chk("lavar_coin_cred", int'(credito), 0);
    chk("lavar_coin_phase", int'(ph()), int'(LAV));
    tk();
    #2 reset = 1'b1;
    #1;
    chk("async_rst_parada", int'(parada), 1);
    chk("async_rst_lavar", int'(lavar), 0);
    chk("async_rst_cred", int'(credito), 0);
    @(negedge clk);
    reset = 1'b0;
    tk();
    tk();
    chk("post_rst_idle", int'(ph()), int'(PAR));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wash_cycle_ctrl.md
# wash_cycle_ctrl

Coin-operated washing machine controller with programmable price and phase durations. It accumulates coin credit and returns change. It runs soak, N rounds of wash/rinse, then spin, each phase timed by internal counters driven by a shared `tick` time base. Spin pauses while the lid is open. It sits between the coin-acceptor/panel inputs and the motor/valve drivers, and replaces external `Tempo` timing with self-timed phases.

## Interface
- PRICE, 4: cycle price in 50-cent units (4 = R$2,00)
- CREDIT_W, 4: credit/change width; credit saturates at 2^CREDIT_W-1
- T_MOLHO, 8: soak duration in ticks (≥1)
- T_LAVAR, 12: wash duration in ticks (≥1)
- T_ENXAGUE, 6: rinse duration in ticks (≥1)
- T_CENTRIF, 10: spin duration in ticks (≥1)
- TMR_W, 8: phase timer width; every T_* must be < 2^TMR_W
- MAX_RODADAS, 3: maximum wash/rinse rounds
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; forces all state to reset values
- tick  in  1  time-base enable; phase timers count only when tick=1
- botao_50cent  in  1  one-cycle pulse, +1 credit unit
- botao_1real  in  1  one-cycle pulse, +2 credit units
- cancelar  in  1  in ESPERA: refund all credit as change
- lid_r  in  1  1 = lid open
- n_rodadas  in  2  requested wash/rinse rounds, sampled at start
- molho, lavar, enxague, centrifugar, pausar  out  1  one-hot phase outputs
- parada  out  1  1 while idle in ESPERA
- credito  out  CREDIT_W  current credit
- troco  out  CREDIT_W  change amount, valid with troco_valid
- troco_valid  out  1  one-cycle change pulse
- fim  out  1  one-cycle pulse at cycle completion

## Operation
- States: ESPERA, MOLHO, LAVAR, ENXAGUE, CENTRIFUGAR, PAUSAR. Phase outputs and parada decode the registered state. Exactly one of molho/lavar/enxague/centrifugar/pausar/parada is high at any time.
- **Credit:**
  - Coins are accepted only in ESPERA. Pulses in other states are ignored.
  - Both buttons in the same cycle add 3.
  - The sum saturates at 2^CREDIT_W-1, and the excess is discarded.
- **Start:** in ESPERA with credito ≥ PRICE and lid_r=0:
  - Next state is MOLHO.
  - troco = credito − PRICE, and troco_valid pulses even if troco=0.
  - credito clears to 0, and coins in the start cycle are discarded.
  - Round count is latched as n_rodadas clipped to [1, MAX_RODADAS]; 0 is treated as 1.
  - If credito ≥ PRICE but lid_r=1, the machine stays in ESPERA and holds credit.
- **Cancel:** cancelar in ESPERA with credito>0 and no start condition:
  - troco = credito and troco_valid pulses.
  - credito clears, and coins in that cycle are discarded.
  - Start has priority over cancel. cancelar is ignored outside ESPERA.
- **Phase sequence:** MOLHO → LAVAR → ENXAGUE, repeated for the latched round count, → CENTRIFUGAR → ESPERA. fim pulses in the first ESPERA cycle.
- **Phase timer:**
  - Loaded with T_x on entry to a phase.
  - Decrements on each tick.
  - The phase exits on the clock edge where tick=1 and timer=1.
  - Each phase therefore lasts exactly T_x ticks.
- **Lid:**
  - In CENTRIFUGAR, lid_r=1 moves to PAUSAR and freezes the timer.
  - In PAUSAR, lid_r=0 returns to CENTRIFUGAR with the remaining time preserved.
  - Lid-open takes priority over timer expiry in the same cycle.
  - lid_r is ignored in MOLHO, LAVAR and ENXAGUE.
- The round counter decrements on each ENXAGUE exit.
- **Reset values:**
  - State ESPERA: parada=1, all phase outputs 0.
  - credito=0, troco=0, troco_valid=0, fim=0; timer and round counter 0.
  - Reset mid-cycle aborts the cycle with no refund.

## Timing
- Coin pulse at edge k: credito is updated and visible after edge k.
- Start detected in cycle k: molho=1, troco/troco_valid and credito=0 are all visible after edge k. troco_valid drops after edge k+1.
- With tick tied high and one round, total run time is T_MOLHO+T_LAVAR+T_ENXAGUE+T_CENTRIF cycles, plus any PAUSAR time. Default: 36 cycles.
- Lid open in cycle k during spin: pausar=1 after edge k, and no tick is consumed in cycle k.
- tick low stretches phases. Coin and cancel handling do not depend on tick.

## Test plan
- Reset: assert reset asynchronously mid-LAVAR → immediately parada=1, lavar=0, credito=0. Deassert → remains in ESPERA.
- Exact payment: 50cent, 1real, 50cent (credito 1, 3, 4) → start next cycle, troco=0 with troco_valid=1 for 1 cycle, molho=1, credito=0.
- Overpay and saturation: eight 1real pulses → credito=15 (saturated) → start with troco=11. Simultaneous 50cent+1real in ESPERA from 0 → credito=3.
- Full run, tick=1, n_rodadas=2: durations molho 8, lavar 12, enxague 6, lavar 12, enxague 6, centrifugar 10 cycles → fim pulse, then parada=1. n_rodadas=0 behaves as 1 (36 cycles); n_rodadas=3 gives 3 rounds.
- Lid pause: lid_r=1 after 4 spin cycles for 5 cycles → pausar=1 for 5 cycles, then exactly 6 more centrifugar cycles. Lid open in ESPERA with credito=4 → no start, credit held.
- Cancel: credito=3, cancelar → troco=3, troco_valid=1, credito=0. cancelar during MOLHO → no effect. Coins during LAVAR → credito unchanged.
